// File: rtl/if_id_hazard_ctrl.sv
// IF/ID segment register with load-use stall detection, branch flush and HALT drain control.
// Drives PC write enable and ID/EX bubble requests for the downstream pipeline.
module if_id_hazard_ctrl #(
    parameter logic [5:0]  HALT_OPCODE  = 6'b111111,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_instruction,
    input  logic [31:0] if_pc_plus4,
    input  logic        id_branch_taken,
    input  logic        ex_m_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        resume,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc_plus4,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [5:0]  id_function_code,
    output logic [15:0] id_imm,
    output logic        pc_write,
    output logic        id_ex_bubble,
    output logic        stall,
    output logic        halted
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       pc_q, pc_d;
    logic              halted_q;

    logic [5:0]        opcode;
    logic              uses_rt;
    logic              halt_det;

    assign opcode           = ir_q[31:26];
    assign id_instruction   = ir_q;
    assign id_pc_plus4      = pc_q;
    assign id_rs            = ir_q[25:21];
    assign id_rt            = ir_q[20:16];
    assign id_rd            = ir_q[15:11];
    assign id_function_code = ir_q[5:0];
    assign id_imm           = ir_q[15:0];
    assign halted           = halted_q;

    // Hazard decode: rt is a source only for R-type, beq/bne and stores
    always_comb begin
        uses_rt  = (opcode == 6'b000000) || (opcode == 6'b000100) ||
                   (opcode == 6'b000101) || (opcode[5:3] == 3'b101);
        stall    = ex_m_mem_read && (ex_rt != 5'd0) &&
                   ((ex_rt == ir_q[25:21]) || (uses_rt && (ex_rt == ir_q[20:16])));
        halt_det = (state_q == ST_RUN) && (opcode == HALT_OPCODE) && !stall;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            ir_q     <= '0;
            pc_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ir_q     <= ir_d;
            pc_q     <= pc_d;
            halted_q <= (state_d == ST_HALTED);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (halt_det) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = ST_HALTED;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Stall beats flush: branch operands are not valid during a load-use stall
    always_comb begin
        ir_d         = ir_q;
        pc_d         = pc_q;
        pc_write     = (state_q == ST_RUN) && !stall && !halt_det;
        id_ex_bubble = stall || halt_det || (state_q != ST_RUN);
        if (stall) begin
            ir_d = ir_q;
            pc_d = pc_q;
        end else if ((state_q != ST_RUN) || halt_det || id_branch_taken) begin
            ir_d = '0;
            pc_d = '0;
        end else begin
            ir_d = if_instruction;
            pc_d = if_pc_plus4;
        end
    end

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Self-checking bench for if_id_hazard_ctrl: directed vectors, a reference model
// compared every cycle, and hand-computed spot values.
module tb_if_id_hazard_ctrl;

    localparam int         D       = 3;
    localparam logic [5:0] HALT_OP = 6'b111111;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_instruction  = '0;
    logic [31:0] if_pc_plus4     = '0;
    logic        id_branch_taken = 1'b0;
    logic        ex_m_mem_read   = 1'b0;
    logic [4:0]  ex_rt           = '0;
    logic        resume          = 1'b0;

    logic [31:0] id_instruction, id_pc_plus4;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [5:0]  id_function_code;
    logic [15:0] id_imm;
    logic        pc_write, id_ex_bubble, stall, halted;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    if_id_hazard_ctrl #(.HALT_OPCODE(HALT_OP), .DRAIN_CYCLES(D)) dut (
        .clk              (clk),
        .reset            (reset),
        .if_instruction   (if_instruction),
        .if_pc_plus4      (if_pc_plus4),
        .id_branch_taken  (id_branch_taken),
        .ex_m_mem_read    (ex_m_mem_read),
        .ex_rt            (ex_rt),
        .resume           (resume),
        .id_instruction   (id_instruction),
        .id_pc_plus4      (id_pc_plus4),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_rd            (id_rd),
        .id_function_code (id_function_code),
        .id_imm           (id_imm),
        .pc_write         (pc_write),
        .id_ex_bubble     (id_ex_bubble),
        .stall            (stall),
        .halted           (halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_age counts cycles since HALT sat in ID (0 = running)
    logic [31:0] m_ir = '0;
    logic [31:0] m_pc = '0;
    int          m_age = 0;
    logic        e_stall, e_halt_det, e_pc_write, e_bubble, e_halted;

    function automatic logic f_uses_rt(input logic [5:0] op);
        return (op == 6'd0) || (op == 6'b000100) || (op == 6'b000101) || (op[5:3] == 3'b101);
    endfunction

    always_comb begin
        e_stall    = ex_m_mem_read && (ex_rt != 5'd0) &&
                     ((ex_rt == m_ir[25:21]) || (f_uses_rt(m_ir[31:26]) && (ex_rt == m_ir[20:16])));
        e_halt_det = (m_age == 0) && (m_ir[31:26] == HALT_OP) && !e_stall;
        e_pc_write = (m_age == 0) && !e_stall && !e_halt_det;
        e_bubble   = e_stall || e_halt_det || (m_age != 0);
        e_halted   = (m_age > D);
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ir  <= '0;
            m_pc  <= '0;
            m_age <= 0;
        end else begin
            if (!e_stall) begin
                if (m_age != 0 || e_halt_det || id_branch_taken) begin
                    m_ir <= '0;
                    m_pc <= '0;
                end else begin
                    m_ir <= if_instruction;
                    m_pc <= if_pc_plus4;
                end
            end
            if (e_halt_det)                  m_age <= 1;
            else if (m_age > 0 && m_age <= D) m_age <= m_age + 1;
            else if (m_age > D && resume)     m_age <= 0;
        end
    end

    always @(negedge clk) begin
        chk("instr",  id_instruction,   m_ir);
        chk("pc4",    id_pc_plus4,      m_pc);
        chk("rs",     32'(id_rs),       32'(m_ir[25:21]));
        chk("rt",     32'(id_rt),       32'(m_ir[20:16]));
        chk("rd",     32'(id_rd),       32'(m_ir[15:11]));
        chk("funct",  32'(id_function_code), 32'(m_ir[5:0]));
        chk("imm",    32'(id_imm),      32'(m_ir[15:0]));
        chk("stall",  32'(stall),       32'(e_stall));
        chk("pcw",    32'(pc_write),    32'(e_pc_write));
        chk("bubble", 32'(id_ex_bubble), 32'(e_bubble));
        chk("halted", 32'(halted),      32'(e_halted));
    end

    task automatic cyc(input logic [31:0] ins, input logic [31:0] pc, input logic br,
                       input logic mr, input logic [4:0] rt, input logic res);
        @(posedge clk);
        #1;
        if_instruction  = ins;
        if_pc_plus4     = pc;
        id_branch_taken = br;
        ex_m_mem_read   = mr;
        ex_rt           = rt;
        resume          = res;
        @(negedge clk);
    endtask

    logic [31:0] tbl [8];

    initial begin
        tbl[0] = 32'h012A4020; tbl[1] = 32'h20090005; tbl[2] = 32'hAC090004; tbl[3] = 32'h8C080004;
        tbl[4] = 32'h01095020; tbl[5] = 32'hFC000000; tbl[6] = 32'h11280003; tbl[7] = 32'h00000000;

        reset = 1'b1;
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_instr",  id_instruction, 32'h0);
        chk("rst_pcw",    32'(pc_write), 32'd1);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_bubble", 32'(id_ex_bubble), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Load-use on rs
        cyc(32'h012A4020, 32'h104, 1'b0, 1'b0, 5'd0, 1'b0);
        cyc(32'h01095020, 32'h108, 1'b0, 1'b1, 5'd9, 1'b0);
        chk("lu_instr",  id_instruction, 32'h012A4020);
        chk("lu_stall",  32'(stall), 32'd1);
        chk("lu_pcw",    32'(pc_write), 32'd0);
        chk("lu_bubble", 32'(id_ex_bubble), 32'd1);
        chk("lu_rd",     32'(id_rd), 32'd8);
        cyc(32'h01095020, 32'h108, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("lu_hold",   id_instruction, 32'h012A4020);
        chk("lu_pc",     id_pc_plus4, 32'h104);
        cyc(32'h20090005, 32'h10C, 1'b0, 1'b1, 5'd0, 1'b0);
        chk("lu_rt0",    32'(stall), 32'd0);

        // rt-only hazards: addi ignores rt, sw uses it
        cyc(32'hAC090004, 32'h110, 1'b0, 1'b1, 5'd9, 1'b0);
        chk("addi_nostall", 32'(stall), 32'd0);
        cyc(32'h00000000, 32'h114, 1'b0, 1'b1, 5'd9, 1'b0);
        chk("sw_stall",  32'(stall), 32'd1);
        cyc(32'h00000000, 32'h114, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("sw_hold",   id_instruction, 32'hAC090004);

        // Branch flush, then flush suppressed by stall
        cyc(32'h8C080004, 32'h118, 1'b1, 1'b0, 5'd0, 1'b0);
        cyc(32'h012A4020, 32'h11C, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("flush_instr", id_instruction, 32'h0);
        cyc(32'h8C080004, 32'h120, 1'b1, 1'b1, 5'd9, 1'b0);
        chk("br_stall",  32'(stall), 32'd1);
        cyc(32'h8C080004, 32'h120, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("br_hold",   id_instruction, 32'h012A4020);
        cyc(32'hFC000000, 32'h200, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("lw_in",     id_instruction, 32'h8C080004);

        // HALT drain (N = first cycle below), early resume ignored
        cyc(32'h01095020, 32'h204, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("h_instr",  id_instruction, 32'hFC000000);
        chk("h_pcw",    32'(pc_write), 32'd0);
        chk("h_bubble", 32'(id_ex_bubble), 32'd1);
        cyc(32'h01095020, 32'h204, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("h1_instr", id_instruction, 32'h0);
        cyc(32'h01095020, 32'h204, 1'b0, 1'b0, 5'd0, 1'b1);
        cyc(32'h01095020, 32'h204, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("h3_bubble", 32'(id_ex_bubble), 32'd1);
        chk("h3_halted", 32'(halted), 32'd0);
        chk("h3_pcw",    32'(pc_write), 32'd0);
        cyc(32'h01095020, 32'h204, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("h4_halted", 32'(halted), 32'd1);
        cyc(32'h01095020, 32'h204, 1'b0, 1'b0, 5'd0, 1'b1);
        cyc(32'h01095020, 32'h204, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("res_pcw",    32'(pc_write), 32'd1);
        chk("res_halted", 32'(halted), 32'd0);
        cyc(32'h012A4020, 32'h208, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("res_instr", id_instruction, 32'h01095020);
        chk("res_pc",    id_pc_plus4, 32'h204);

        // Asynchronous reset while draining
        cyc(32'hFC000000, 32'h300, 1'b0, 1'b0, 5'd0, 1'b0);
        cyc(32'h00000000, 32'h304, 1'b0, 1'b0, 5'd0, 1'b0);
        cyc(32'h00000000, 32'h304, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("rd_bubble_pre", 32'(id_ex_bubble), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rd_pcw",    32'(pc_write), 32'd1);
        chk("rd_bubble", 32'(id_ex_bubble), 32'd0);
        chk("rd_halted", 32'(halted), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rd_rel_pcw",   32'(pc_write), 32'd1);
        chk("rd_rel_instr", id_instruction, 32'h0);

        // Table-driven mix, checked by the model every cycle
        for (int i = 0; i < 60; i++) begin
            cyc(tbl[(i * 3) % 8], 32'h400 + 32'(i * 4), (i % 7) == 2, (i % 3) == 1,
                ((i % 2) == 1) ? 5'd9 : 5'd8, (i % 6) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_id_hazard_ctrl.md
# if_id_hazard_ctrl

IF/ID segment register with integrated load-use hazard detection, branch flush and HALT drain control. It sits directly upstream of the ID/EX segment register. It latches the fetched instruction and PC+4, splits the instruction into the register/function fields that ID/EX consumes, and tells the PC and ID/EX when to stall, bubble or stop.

## Interface
Parameters:
- `HALT_OPCODE`, default 6'b111111: opcode that starts the pipeline drain.
- `DRAIN_CYCLES`, default 3: cycles needed to empty EX, MEM and WB after HALT.

Ports:
- `clk`, in, 1: rising-edge clock.
- `reset`, in, 1: asynchronous, active-low reset (0 = reset).
- `if_instruction`, in, 32: instruction from instruction memory.
- `if_pc_plus4`, in, 32: PC+4 of the fetched instruction.
- `id_branch_taken`, in, 1: ID-stage branch/jump resolved taken; request to flush IF/ID.
- `ex_m_mem_read`, in, 1: instruction now in EX is a load.
- `ex_rt`, in, 5: destination register of the instruction in EX.
- `resume`, in, 1: single-cycle pulse that leaves the HALTED state.
- `id_instruction`, out, 32: latched instruction.
- `id_pc_plus4`, out, 32: latched PC+4.
- `id_rs`, `id_rt`, `id_rd`, out, 5 each: bits [25:21], [20:16] and [15:11] of `id_instruction`.
- `id_function_code`, out, 6: bits [5:0] of `id_instruction`.
- `id_imm`, out, 16: bits [15:0] of `id_instruction`.
- `pc_write`, out, 1: PC update enable.
- `id_ex_bubble`, out, 1: ID/EX must load zero control signals this cycle.
- `stall`, out, 1: load-use stall is active.
- `halted`, out, 1: pipeline has drained and is stopped.

## Operation
- Field outputs are combinational slices of the registered `id_instruction`.
- `uses_rt` is 1 when opcode = 0 (R-type), opcode = 000100 or 000101 (beq/bne), or opcode[5:3] = 101 (stores).
- `stall` = `ex_m_mem_read` and `ex_rt` ≠ 0 and (`ex_rt` = `id_rs`, or (`uses_rt` and `ex_rt` = `id_rt`)).
- `halt_det` = state is RUN, opcode = `HALT_OPCODE`, and `stall` = 0.
- FSM states and transitions:
  - RUN goes to DRAIN on `halt_det`; the counter loads `DRAIN_CYCLES`−1.
  - DRAIN decrements the counter each cycle; when the counter is 0 it goes to HALTED.
  - HALTED goes to RUN on `resume`.
  - `resume` is ignored in RUN and DRAIN.
- IF/ID register update, highest priority first:
  1. `stall`: hold all values.
  2. State is DRAIN or HALTED, or `halt_det`: load the NOP (instruction 0, PC+4 0).
  3. `id_branch_taken`: load the NOP.
  4. Otherwise: load `if_instruction` and `if_pc_plus4`.
- `pc_write` = state is RUN, and not `stall`, and not `halt_det`.
- `id_ex_bubble` = `stall` or `halt_det` or state is DRAIN or HALTED. The HALT instruction itself never enters EX.
- A stall wins over a branch flush, because branch operands are invalid during a load-use stall. The flush is re-evaluated once the stall clears.
- PC holds at HALT+4 throughout DRAIN and HALTED. After `resume`, HALT+4 is refetched, so no instruction is lost.

## Timing
- Reset (`reset` = 0) takes effect asynchronously:
  - `id_instruction` = 0 and `id_pc_plus4` = 0, so all field outputs are 0.
  - State = RUN, counter = 0, `halted` = 0.
  - `stall`, `id_ex_bubble` and `pc_write` follow from these values: 0, 0 and 1.
- Reset may arrive mid-DRAIN or in HALTED; it returns the block to RUN immediately.
- IF→ID latency is 1 cycle.
- A load-use stall lasts exactly 1 cycle: on the next edge the load leaves EX and the bubble now in EX has `ex_m_mem_read` = 0.
- HALT handling:
  - HALT is in ID in cycle N, with `pc_write` = 0 and bubble = 1.
  - DRAIN covers cycles N+1 to N+`DRAIN_CYCLES`.
  - `halted` = 1 from cycle N+`DRAIN_CYCLES`+1.
- `resume` sampled high in HALTED: state is RUN and `pc_write` = 1 on the next cycle.
- `halted` is registered, decoded directly from the state.

## Test plan
- Reset mid-DRAIN: drive `reset` low asynchronously between clock edges.
  - Outputs clear immediately, and `halted` stays 0.
  - After release: `pc_write` = 1 and `id_instruction` = 0.
- Load-use: `id_instruction` = 0x012A4020 (add $8,$9,$10) with `ex_m_mem_read` = 1 and `ex_rt` = 9.
  - `stall` = 1, `pc_write` = 0, `id_ex_bubble` = 1, and IF/ID holds for one cycle.
  - With `ex_rt` = 0 there is no stall.
- rt-only hazard: addi (opcode 001000, rt = 9) with `ex_rt` = 9 gives no stall. sw (opcode 101011, rt = 9) with `ex_rt` = 9 gives a stall.
- Branch flush: `id_branch_taken` = 1 with `if_instruction` = 0x8C080004.
  - Next cycle `id_instruction` = 0.
  - With `stall` = 1 in the same cycle, IF/ID holds instead.
- HALT drain: 0xFC000000 enters ID at cycle N.
  - `pc_write` = 0 from N onward.
  - `id_ex_bubble` = 1 for N to N+3.
  - `halted` = 1 at N+4.
  - `resume` pulse: `pc_write` = 1 and the next instruction is latched.
